// File: rtl/spi_pixel_framer.sv
// SPI byte stream -> double-banked per-channel LED pixel store with brightness-scaled readout.
// Frames carry a channel byte, a brightness byte, then packed pixels; reads take two cycles.
module spi_pixel_framer #(
  parameter int NUM_LEDS      = 8,
  parameter int NUM_CHANNELS  = 2,
  parameter int BYTES_PER_LED = 3,
  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int AW = $clog2(NUM_LEDS),
  localparam int DW = 8 * BYTES_PER_LED
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          SSEL,
  input  logic [7:0]    RX_DATA,
  input  logic          RX_READY,
  input  logic [CW-1:0] RD_CHAN,
  input  logic [AW-1:0] RD_ADDR,
  input  logic          RD_REQ,
  input  logic          RD_SYNC,
  output logic [DW-1:0] RD_DATA,
  output logic          RD_VALID,
  output logic          FRAME_DONE,
  output logic          ERR
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] HDR_CHAN   = 3'd1;
  localparam logic [2:0] HDR_BRIGHT = 3'd2;
  localparam logic [2:0] PIXELS     = 3'd3;
  localparam logic [2:0] DISCARD    = 3'd4;

  localparam int BIW   = (BYTES_PER_LED > 2) ? $clog2(BYTES_PER_LED) : 1;
  localparam int MAW   = CW + 1 + AW;
  localparam int DEPTH = 1 << MAW;

  // SSEL synchronizer plus one history flop for edge detection
  logic [1:0] ssel_sync;
  logic       ssel_prev;
  logic       fall;
  logic       rise;

  always_ff @(posedge CLK) begin
    if (RST) begin
      ssel_sync <= 2'b11;
      ssel_prev <= 1'b1;
    end else begin
      ssel_sync <= {ssel_sync[0], SSEL};
      ssel_prev <= ssel_sync[1];
    end
  end

  assign fall = ssel_prev & ~ssel_sync[1];
  assign rise = ~ssel_prev & ssel_sync[1];

  logic [2:0]     state;
  logic [CW-1:0]  chan_q;
  logic [7:0]     bright_q;
  logic [AW:0]    led_cnt;
  logic [BIW-1:0] byte_idx;
  logic [DW-9:0]  pix_sr;

  logic           pix_byte;
  logic           last_byte;
  logic           full;
  logic           wr_en;
  logic           commit;
  logic [DW-1:0]  wr_word;
  logic [MAW-1:0] wr_addr;
  logic [AW:0]    cnt_after;

  logic [NUM_CHANNELS-1:0] wb;
  logic [NUM_CHANNELS-1:0] wb_next;
  logic [NUM_CHANNELS-1:0] db;
  logic [AW:0]             cnt_tab [NUM_CHANNELS][2];
  logic [7:0]              b_tab   [NUM_CHANNELS][2];

  assign pix_byte  = (state == PIXELS) && RX_READY;
  assign last_byte = (byte_idx == BIW'(BYTES_PER_LED - 1));
  assign full      = (led_cnt == (AW+1)'(NUM_LEDS));
  assign wr_en     = !RST && pix_byte && !full && last_byte;
  assign wr_word   = {pix_sr, RX_DATA};
  assign wr_addr   = {chan_q, wb[chan_q], led_cnt[AW-1:0]};
  // a byte landing in the same cycle as the rise is counted before the commit
  assign cnt_after = led_cnt + (wr_en ? (AW+1)'(1) : (AW+1)'(0));
  assign commit    = !RST && (state == PIXELS) && rise;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      chan_q   <= '0;
      bright_q <= 8'hFF;
      led_cnt  <= '0;
      byte_idx <= '0;
      pix_sr   <= '0;
      ERR      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fall) begin
            state    <= HDR_CHAN;
            led_cnt  <= '0;
            byte_idx <= '0;
          end
        end
        HDR_CHAN: begin
          if (rise) begin
            state <= IDLE;
          end else if (RX_READY) begin
            if (RX_DATA < 8'(NUM_CHANNELS)) begin
              chan_q <= RX_DATA[CW-1:0];
              state  <= HDR_BRIGHT;
            end else begin
              ERR   <= 1'b1;
              state <= DISCARD;
            end
          end
        end
        HDR_BRIGHT: begin
          if (rise) begin
            state <= IDLE;
          end else if (RX_READY) begin
            bright_q <= RX_DATA;
            state    <= PIXELS;
          end
        end
        PIXELS: begin
          if (pix_byte) begin
            if (full) begin
              ERR <= 1'b1;
            end else if (last_byte) begin
              byte_idx <= '0;
              led_cnt  <= led_cnt + (AW+1)'(1);
            end else begin
              byte_idx <= byte_idx + BIW'(1);
              pix_sr   <= wr_word[DW-9:0];
            end
          end
          if (rise) state <= IDLE;
        end
        DISCARD: begin
          if (rise) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    wb_next = wb;
    if (commit) wb_next[chan_q] = ~wb[chan_q];
  end

  // display bank always shows the last committed bank, including one committed this cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      wb         <= '0;
      db         <= '0;
      FRAME_DONE <= 1'b0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        for (int k = 0; k < 2; k++) begin
          cnt_tab[c][k] <= '0;
          b_tab[c][k]   <= 8'hFF;
        end
      end
    end else begin
      wb         <= wb_next;
      FRAME_DONE <= commit;
      if (RD_SYNC) db <= ~wb_next;
      if (commit) begin
        cnt_tab[chan_q][wb[chan_q]] <= cnt_after;
        b_tab[chan_q][wb[chan_q]]   <= bright_q;
      end
    end
  end

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_word;
  end

  logic           chan_ok;
  logic           rd_bank;
  logic [AW:0]    rd_cnt;
  logic [DW-1:0]  rd_word;
  logic           s1_vld;
  logic           s1_hit;
  logic [7:0]     s1_b;
  logic [DW-1:0]  scaled;
  logic [15:0]    prod;

  assign chan_ok = ({1'b0, RD_CHAN} < (CW+1)'(NUM_CHANNELS));
  assign rd_bank = db[RD_CHAN];
  assign rd_cnt  = cnt_tab[RD_CHAN][rd_bank];

  always_ff @(posedge CLK) begin
    if (RD_REQ) rd_word <= mem[{RD_CHAN, rd_bank, RD_ADDR}];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_vld <= 1'b0;
      s1_hit <= 1'b0;
      s1_b   <= 8'hFF;
    end else begin
      s1_vld <= RD_REQ;
      if (RD_REQ) begin
        s1_hit <= chan_ok && ({1'b0, RD_ADDR} < rd_cnt);
        s1_b   <= b_tab[RD_CHAN][rd_bank];
      end
    end
  end

  // (byte * (B+1)) >> 8 per byte lane; 255*256 still fits in 16 bits
  always_comb begin
    scaled = '0;
    prod   = '0;
    for (int i = 0; i < BYTES_PER_LED; i++) begin
      prod = 16'(rd_word[i*8 +: 8]) * (16'(s1_b) + 16'd1);
      scaled[i*8 +: 8] = prod[15:8];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      RD_VALID <= 1'b0;
      RD_DATA  <= '0;
    end else begin
      RD_VALID <= s1_vld;
      if (s1_vld) RD_DATA <= s1_hit ? scaled : '0;
    end
  end

endmodule
